// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared constants and types for the USB transmit path
package usb_tx_pkg;

    localparam int TX_FIFO_DEPTH   = 64;
    localparam int TX_FIFO_ADDR_W  = 6;
    localparam int USB_MAX_PAYLOAD = 64;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/tx_fifo_mem.sv
// rtl/tx_fifo_mem.sv - byte register file, synchronous write, asynchronous read
module tx_fifo_mem
    import usb_tx_pkg::*;
#(
    parameter int DEPTH  = TX_FIFO_DEPTH,
    parameter int ADDR_W = TX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  byte_t             i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output byte_t             o_rdata
);

    // Contents are deliberately left unreset; readers gate with occupancy.
    byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tx_fifo.sv
// rtl/tx_fifo.sv - show-ahead byte FIFO feeding the USB transmitter
// Pointers, occupancy, threshold flag and sticky error flags live here.
module tx_fifo
    import usb_tx_pkg::*;
#(
    parameter int DEPTH        = TX_FIFO_DEPTH,
    parameter int ADDR_W       = TX_FIFO_ADDR_W,
    parameter int READY_THRESH = USB_MAX_PAYLOAD
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            clear,
    input  logic            w_enable,
    input  byte_t           w_data,
    input  logic            fifo_r_enable,
    output byte_t           fifo_byte,
    output logic            empty,
    output logic            full,
    output logic [ADDR_W:0] count,
    output logic            packet_ready,
    output logic            overrun,
    output logic            underrun
);

    localparam logic [ADDR_W:0] C_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_THRESH = (ADDR_W+1)'(READY_THRESH);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overrun;
    logic              r_underrun;

    logic              w_empty;
    logic              w_rd_ok;
    logic              w_rd_bad;
    logic              w_wr_ok;
    logic              w_wr_drop;
    logic              w_mem_we;
    byte_t             w_rdata;

    assign w_empty = (r_count == '0);

    // A write into a full FIFO is still legal when a read frees a slot this cycle.
    always_comb begin
        w_rd_ok   = 1'b0;
        w_rd_bad  = 1'b0;
        w_wr_ok   = 1'b0;
        w_wr_drop = 1'b0;
        if (fifo_r_enable) begin
            if (w_empty) begin
                w_rd_bad = 1'b1;
            end else begin
                w_rd_ok = 1'b1;
            end
        end
        if (w_enable) begin
            if ((r_count < C_DEPTH) || w_rd_ok) begin
                w_wr_ok = 1'b1;
            end else begin
                w_wr_drop = 1'b1;
            end
        end
    end

    // Reset and clear must also block the memory write, not just the pointer bump.
    assign w_mem_we = w_wr_ok && n_rst && !clear;

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_drop) begin
                r_overrun <= 1'b1;
            end
            if (w_rd_bad) begin
                r_underrun <= 1'b1;
            end
        end
    end

    tx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign fifo_byte    = w_empty ? 8'h00 : w_rdata;
    assign empty        = w_empty;
    assign full         = (r_count == C_DEPTH);
    assign count        = r_count;
    assign packet_ready = (r_count >= C_THRESH);
    assign overrun      = r_overrun;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_tx_fifo.sv
// tb/tb_tx_fifo.sv - scoreboard bench for tx_fifo with a queue-based reference model
module tb_tx_fifo;
    import usb_tx_pkg::*;

    localparam int DEPTH = 64;
    localparam int THRESH = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       clear = 1'b0;
    logic       w_enable = 1'b0;
    byte_t      w_data = 8'h00;
    logic       fifo_r_enable = 1'b0;
    byte_t      fifo_byte;
    logic       empty;
    logic       full;
    logic [6:0] count;
    logic       packet_ready;
    logic       overrun;
    logic       underrun;

    int    n_pass = 0;
    int    n_total = 0;
    byte_t mq[$];
    byte_t sb[$];
    bit    m_ovr = 1'b0;
    bit    m_unr = 1'b0;

    always #5 clk = ~clk;

    tx_fifo dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .w_enable      (w_enable),
        .w_data        (w_data),
        .fifo_r_enable (fifo_r_enable),
        .fifo_byte     (fifo_byte),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .packet_ready  (packet_ready),
        .overrun       (overrun),
        .underrun      (underrun)
    );

    function automatic void chk(string nm, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    endfunction

    task automatic check_status();
        int sz;
        int exp_byte;
        sz = mq.size();
        exp_byte = (sz > 0) ? int'(mq[0]) : 0;
        chk("count", int'(count), sz);
        chk("empty", int'(empty), int'(sz == 0));
        chk("full", int'(full), int'(sz == DEPTH));
        chk("packet_ready", int'(packet_ready), int'(sz >= THRESH));
        chk("overrun", int'(overrun), int'(m_ovr));
        chk("underrun", int'(underrun), int'(m_unr));
        chk("head_byte", int'(fifo_byte), exp_byte);
    endtask

    task automatic step(bit rst, bit clr, bit we, byte_t wd, bit re);
        int sz;
        bit rd_ok;
        bit wr_ok;
        n_rst = !rst;
        clear = clr;
        w_enable = we;
        w_data = wd;
        fifo_r_enable = re;
        @(posedge clk);
        sz = mq.size();
        if (rst || clr) begin
            mq.delete();
            sb.delete();
            m_ovr = 1'b0;
            m_unr = 1'b0;
        end else begin
            rd_ok = re && (sz > 0);
            wr_ok = we && ((sz < DEPTH) || rd_ok);
            if (rd_ok) void'(mq.pop_front());
            if (wr_ok) begin
                mq.push_back(wd);
                sb.push_back(wd);
            end
            if (we && !wr_ok) m_ovr = 1'b1;
            if (re && sz == 0) m_unr = 1'b1;
        end
        #1;
        check_status();
    endtask

    // Monitor: every byte the transmitter consumes must be the next one the scoreboard expects.
    initial begin
        forever begin
            @(negedge clk);
            if (n_rst && !clear && fifo_r_enable && !empty) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL rd_byte: DUT offered 0x%0h with no byte expected at %0t", fifo_byte, $time);
                end else begin
                    chk("rd_byte", int'(fifo_byte), int'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int ph;
        int wp;
        int rp;
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        step(0, 0, 0, 8'h00, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_byte", int'(fifo_byte), 0);

        for (int i = 0; i < 64; i++) step(0, 0, 1, byte_t'(i), 0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 64);
        chk("fill_ready", int'(packet_ready), 1);

        step(0, 0, 1, 8'hAA, 0);
        chk("ovr_set", int'(overrun), 1);
        chk("ovr_count", int'(count), 64);
        chk("ovr_head", int'(fifo_byte), 8'h01 - 8'h01);

        step(0, 0, 1, 8'h55, 1);
        chk("rw_full_count", int'(count), 64);
        for (int i = 0; i < 64; i++) step(0, 0, 0, 8'h00, 1);
        chk("drain_empty", int'(empty), 1);

        step(0, 0, 1, 8'h7E, 1);
        chk("unr_set", int'(underrun), 1);
        chk("unr_count", int'(count), 1);
        chk("unr_byte", int'(fifo_byte), 8'h7E);
        step(0, 0, 0, 8'h00, 1);

        for (int i = 0; i < 32; i++) step(0, 0, 1, byte_t'($urandom), 0);
        for (int i = 0; i < 25; i++) begin
            step(0, 0, 1, byte_t'($urandom), 0);
            chk("wrap_range", int'(count >= 31 && count <= 33), 1);
            step(0, 0, 0, 8'h00, 1);
            chk("wrap_range", int'(count >= 31 && count <= 33), 1);
            step(0, 0, 0, 8'h00, 1);
            chk("wrap_range", int'(count >= 31 && count <= 33), 1);
            step(0, 0, 1, byte_t'($urandom), 0);
            chk("wrap_range", int'(count >= 31 && count <= 33), 1);
        end

        for (int i = 0; i < 12; i++) step(0, 0, 0, 8'h00, 1);
        chk("pre_clr_count", int'(count), 20);
        chk("pre_clr_ovr", int'(overrun), 1);
        step(0, 1, 1, 8'hC3, 0);
        chk("clr_count", int'(count), 0);
        chk("clr_empty", int'(empty), 1);
        chk("clr_ovr", int'(overrun), 0);
        step(0, 0, 1, 8'h11, 0);
        chk("post_clr_head", int'(fifo_byte), 8'h11);

        // Random traffic with phases biased towards filling, balance and draining.
        for (int i = 0; i < 3000; i++) begin
            ph = (i / 250) % 3;
            wp = (ph == 0) ? 85 : (ph == 1) ? 50 : 15;
            rp = (ph == 0) ? 15 : (ph == 1) ? 50 : 85;
            step($urandom_range(0, 599) == 0, $urandom_range(0, 249) == 0,
                 $urandom_range(0, 99) < wp, byte_t'($urandom), $urandom_range(0, 99) < rp);
        end

        step(0, 0, 0, 8'h00, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
- 64-byte show-ahead data buffer directly upstream of the USB transmitter.
- Host/AHB-side logic writes payload bytes; the transmitter consumes them by holding fifo_byte and pulsing fifo_r_enable once per byte sent.
- Provides occupancy, a packet-ready threshold flag, and sticky overrun/underrun error flags for the receiver/host-side controller.

Parameters:
- DEPTH, 64, number of byte entries; must be a power of two ≥ 2.
- ADDR_W, 6, log2(DEPTH); pointer width.
- READY_THRESH, 64, occupancy at or above which packet_ready asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- clear  in  1  synchronous flush; empties the FIFO and clears the error flags
- w_enable  in  1  write strobe; one byte per cycle
- w_data  in  8  byte to write
- fifo_r_enable  in  1  read/advance strobe from transmitter
- fifo_byte  out  8  head-of-FIFO byte (show-ahead)
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- packet_ready  out  1  count >= READY_THRESH
- overrun  out  1  sticky: write attempted while full with no simultaneous read
- underrun  out  1  sticky: read attempted while empty

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is synchronous and active-low.
- Reset state, sampled on the clk edge with n_rst=0:
  - wr_ptr = rd_ptr = 0, count = 0.
  - empty = 1, full = 0, packet_ready = 0.
  - overrun = underrun = 0.
  - Memory contents are not reset; fifo_byte = 8'h00 while empty.
- Priority order: n_rst > clear > read/write. clear has the same effect as reset, except that memory is not touched.
- Write:
  - When w_enable=1 and (count<DEPTH, or fifo_r_enable=1 with count>0): mem[wr_ptr] <= w_data, and wr_ptr increments modulo DEPTH (natural wrap).
  - Otherwise the write is dropped and overrun <= 1.
- Read:
  - When fifo_r_enable=1 and count>0: rd_ptr increments modulo DEPTH.
  - When fifo_r_enable=1 and count==0: no pointer change and underrun <= 1. A write in the same cycle is still accepted.
- Count:
  - +1 on an accepted write only, -1 on an accepted read only.
  - Unchanged on both or neither.
  - Width is ADDR_W+1, so count must never wrap.
- Show-ahead output:
  - fifo_byte = mem[rd_ptr] combinationally whenever count>0, and 8'h00 when empty.
  - A byte written into an empty FIFO appears on fifo_byte in the cycle after the write edge (1-cycle write-to-read latency).
  - After a read edge, the next byte is valid in the following cycle.
- Flags: empty, full and packet_ready are derived combinationally from the registered count, so they update in the cycle after the causing edge.
- Sticky errors: overrun and underrun are registered and clear only on n_rst or clear.
- Simultaneous events:
  - Read and write while full: both accepted; count stays at DEPTH and overrun is not set.
  - Read and write while empty: write accepted, read rejected, underrun set, count becomes 1.
  - clear together with w_enable: clear wins and the write is discarded.

Decomposition:
- Shared package usb_tx_pkg holds:
  - TX_FIFO_DEPTH = 64 and TX_FIFO_ADDR_W = 6.
  - USB_MAX_PAYLOAD = 64, reused by the transmitter timer EOD logic.
  - The byte_t typedef (logic [7:0]).
- One sub-module, tx_fifo_mem: DEPTH×8 register file with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr → rdata).
- tx_fifo keeps the pointers, count, flags and control logic.

Test Plan:
- Reset/empty: hold n_rst=0 for 2 clocks, release → count=0, empty=1, full=0, fifo_byte=8'h00, overrun=underrun=0.
- Fill and drain in order:
  - Stimulus: write 8'h00..8'h3F on 64 consecutive cycles.
  - Expected on fill: full=1, count=64, packet_ready=1.
  - Then pulse fifo_r_enable 64 times; expected on drain: fifo_byte sequence 00..3F, empty=1 after the last read.
- Overrun and full simultaneous access:
  - At full, write 8'hAA without a read → overrun=1, count stays 64, data unchanged.
  - Then read and write 8'h55 in the same cycle → count stays 64, and 8'h55 emerges as the 64th byte after it.
- Underrun and empty simultaneous access:
  - When empty, fifo_r_enable=1 together with a write of 8'h7E → underrun=1, count=1, fifo_byte=8'h7E on the next cycle.
- Pointer wrap:
  - Stimulus: interleave 100 writes and reads at 50% occupancy so the pointers wrap past entry 63.
  - Expected: fifo_byte ordering preserved, with count oscillating between 31 and 33.
- Clear mid-operation:
  - With count=20 and overrun=1, assert clear together with w_enable → next cycle count=0, empty=1, overrun=0, and the written byte is not present.
